add_accum_seq: RTL and testbench

//   Multi-operand accumulation sequencer wrapped around the team's 4-bit ripple-carry adder.

---
 rtl/add_accum_seq.sv | 112 +++++++++++
 tb/tb_add_accum_seq.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/add_accum_seq.sv
// Multi-operand accumulation sequencer driving an external 4-bit ripple-carry adder.
// Takes NUM_OPS operands per burst and presents the total with a sticky carry-overflow flag.
module add_accum_seq #(
  parameter int NUM_OPS = 4,
  parameter int CNT_W   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       flush,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] in_data,
  output logic [3:0] add_a,
  output logic [3:0] add_b,
  input  logic [3:0] add_sum,
  input  logic       add_cout,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] out_sum,
  output logic       out_ovf
);

  typedef enum logic [1:0] {
    ACCEPT = 2'd0,
    ADD    = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_OPS - 1);

  state_t           state, state_nx;
  logic [3:0]       acc, acc_nx;
  logic [3:0]       op_reg, op_nx;
  logic             ovf, ovf_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ACCEPT;
      acc    <= 4'd0;
      op_reg <= 4'd0;
      ovf    <= 1'b0;
      cnt    <= '0;
    end else begin
      state  <= state_nx;
      acc    <= acc_nx;
      op_reg <= op_nx;
      ovf    <= ovf_nx;
      cnt    <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    acc_nx   = acc;
    op_nx    = op_reg;
    ovf_nx   = ovf;
    cnt_nx   = cnt;
    case (state)
      ACCEPT: begin
        if (in_valid) begin
          op_nx    = in_data;
          state_nx = ADD;
        end else begin
          state_nx = ACCEPT;
        end
      end
      ADD: begin
        // The adder sees only registers, so its result is ready within this cycle.
        acc_nx = add_sum;
        ovf_nx = ovf | add_cout;
        if (cnt == LAST_CNT) begin
          cnt_nx   = '0;
          state_nx = DONE;
        end else begin
          cnt_nx   = cnt + CNT_W'(1);
          state_nx = ACCEPT;
        end
      end
      DONE: begin
        if (out_ready) begin
          acc_nx   = 4'd0;
          ovf_nx   = 1'b0;
          state_nx = ACCEPT;
        end else begin
          state_nx = DONE;
        end
      end
      default: begin
        state_nx = ACCEPT;
      end
    endcase
    // Flush overrides everything, including an operand offered in the same cycle.
    if (flush) begin
      state_nx = ACCEPT;
      acc_nx   = 4'd0;
      op_nx    = op_reg;
      ovf_nx   = 1'b0;
      cnt_nx   = '0;
    end else begin
      state_nx = state_nx;
    end
  end

  assign in_ready  = (state == ACCEPT);
  assign out_valid = (state == DONE);
  assign out_sum   = out_valid ? acc : 4'd0;
  assign out_ovf   = out_valid & ovf;
  assign add_a     = acc;
  assign add_b     = op_reg;

endmodule

// File: tb/tb_add_accum_seq.sv
// Directed bench for add_accum_seq: a NUM_OPS=4 instance plus a NUM_OPS=1 instance,
// each wired to a behavioural 4-bit adder.
module tb_add_accum_seq;

  logic       clk = 1'b0;
  logic       rst, flush, in_valid, out_ready;
  logic [3:0] in_data;
  logic       in_ready, out_valid, out_ovf, add_cout;
  logic [3:0] add_a, add_b, add_sum, out_sum;

  logic       s1_flush, s1_in_valid, s1_out_ready;
  logic [3:0] s1_in_data;
  logic       s1_in_ready, s1_out_valid, s1_out_ovf, s1_add_cout;
  logic [3:0] s1_add_a, s1_add_b, s1_add_sum, s1_out_sum;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int first_acc = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  assign {add_cout, add_sum}       = {1'b0, add_a} + {1'b0, add_b};
  assign {s1_add_cout, s1_add_sum} = {1'b0, s1_add_a} + {1'b0, s1_add_b};

  add_accum_seq #(.NUM_OPS(4), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .add_a(add_a), .add_b(add_b), .add_sum(add_sum), .add_cout(add_cout),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum), .out_ovf(out_ovf)
  );

  add_accum_seq #(.NUM_OPS(1), .CNT_W(1)) dut1 (
    .clk(clk), .rst(rst), .flush(s1_flush),
    .in_valid(s1_in_valid), .in_ready(s1_in_ready), .in_data(s1_in_data),
    .add_a(s1_add_a), .add_b(s1_add_b), .add_sum(s1_add_sum), .add_cout(s1_add_cout),
    .out_valid(s1_out_valid), .out_ready(s1_out_ready), .out_sum(s1_out_sum), .out_ovf(s1_out_ovf)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Called at a falling edge; returns at the falling edge after the handshake.
  task automatic send_op(input logic [3:0] d);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (!in_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) check_val("in_ready_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1 acc_cyc = cyc;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_out();
    int n;
    n = 0;
    while (!out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) check_val("out_valid_timeout", 32'd0, 32'd1);
  endtask

  task automatic take_result(input string tag, input logic [3:0] s, input logic o);
    wait_out();
    check_val({tag, "_sum"}, 32'(out_sum), 32'(s));
    check_val({tag, "_ovf"}, 32'(out_ovf), 32'(o));
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check_val({tag, "_released"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = 4'd0; out_ready = 1'b0;
    s1_flush = 1'b0; s1_in_valid = 1'b0; s1_in_data = 4'd0; s1_out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_val("rst_in_ready", 32'(in_ready), 32'd1);
    check_val("rst_out_valid", 32'(out_valid), 32'd0);
    check_val("rst_out_sum", 32'(out_sum), 32'd0);
    check_val("rst_add_ab", 32'({add_a, add_b}), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Burst 1: back-to-back 3,4,5,2 and latency from first accept.
    send_op(4'd3);
    first_acc = acc_cyc;
    send_op(4'd4);
    send_op(4'd5);
    send_op(4'd2);
    wait_out();
    check_val("b1_latency", 32'(cyc - first_acc + 1), 32'd8);
    take_result("b1", 4'd14, 1'b0);

    // Burst 2: overflow on first add, then held result under back-pressure.
    send_op(4'd9);
    send_op(4'd8);
    send_op(4'd1);
    send_op(4'd1);
    wait_out();
    in_valid = 1'b1;
    in_data  = 4'd7;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_val("hold_sum", 32'(out_sum), 32'd3);
      check_val("hold_ovf", 32'(out_ovf), 32'd1);
      check_val("hold_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    take_result("b2", 4'd3, 1'b1);
    send_op(4'd1);
    send_op(4'd1);
    send_op(4'd1);
    send_op(4'd1);
    take_result("b3", 4'd4, 1'b0);

    // Asynchronous reset in the middle of the second ADD.
    send_op(4'd5);
    in_valid = 1'b1;
    in_data  = 4'd6;
    for (int n = 0; n < 40 && !in_ready; n++) @(negedge clk);
    @(posedge clk);
    #2 in_valid = 1'b0;
    check_val("pre_rst_add_a", 32'(add_a), 32'd5);
    check_val("pre_rst_add_b", 32'(add_b), 32'd6);
    rst = 1'b1;
    #1;
    check_val("arst_in_ready", 32'(in_ready), 32'd1);
    check_val("arst_add_ab", 32'({add_a, add_b}), 32'd0);
    check_val("arst_out", 32'({out_valid, out_sum, out_ovf}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    send_op(4'd2);
    send_op(4'd2);
    send_op(4'd2);
    send_op(4'd2);
    take_result("b4", 4'd8, 1'b0);

    // Flush while an operand is offered: it must not be taken.
    in_valid = 1'b1;
    in_data  = 4'd9;
    flush    = 1'b1;
    @(negedge clk);
    flush    = 1'b0;
    in_valid = 1'b0;
    check_val("flush_no_accept", 32'(in_ready), 32'd1);
    check_val("flush_add_b", 32'(add_b), 32'd2);

    // Flush a pending result of 15.
    send_op(4'd3);
    send_op(4'd4);
    send_op(4'd5);
    send_op(4'd3);
    wait_out();
    check_val("b5_pending", 32'({out_sum, out_ovf}), 32'({4'd15, 1'b0}));
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check_val("flush_drop", 32'(out_valid), 32'd0);
    check_val("flush_in_ready", 32'(in_ready), 32'd1);
    send_op(4'd0);
    send_op(4'd0);
    send_op(4'd0);
    send_op(4'd1);
    take_result("b6", 4'd1, 1'b0);

    // Single-operand bursts with random gaps.
    for (int k = 0; k < 4; k++) begin
      int gap;
      int n;
      gap = int'($urandom_range(0, 4));
      repeat (gap) @(negedge clk);
      s1_in_valid = 1'b1;
      s1_in_data  = 4'hF;
      n = 0;
      while (!s1_in_ready && n < 40) begin
        @(negedge clk);
        n++;
      end
      if (n >= 40) check_val("s1_ready_timeout", 32'd0, 32'd1);
      @(negedge clk);
      s1_in_valid = 1'b0;
      n = 0;
      while (!s1_out_valid && n < 40) begin
        @(negedge clk);
        n++;
      end
      if (n >= 40) check_val("s1_valid_timeout", 32'd0, 32'd1);
      check_val("s1_sum", 32'(s1_out_sum), 32'd15);
      check_val("s1_ovf", 32'(s1_out_ovf), 32'd0);
      s1_out_ready = 1'b1;
      @(negedge clk);
      s1_out_ready = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
